// File: rtl/rv_if_pkg.sv
// Shared fetch-stage types and constants.
// The optional IF_FQ_BYPASS_EN feature lives in stage_if_fq.
package rv_if_pkg;

    localparam int INST_BYTES = 4;
    localparam int ENTRY_XLEN = 32;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] pc;
        logic [ENTRY_XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic bit fq_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/stage_if_fq_queue.sv
// Circular prefetch FIFO with push, pop, clear and occupancy count.
// Pop from empty is ignored; clear wins over push and pop.
module if_fetch_queue
    import rv_if_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    input  logic                     clear,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: empty hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/stage_if_fq.sv
// Instruction fetch stage with prefetch queue and redirect handling.
// Define IF_FQ_BYPASS_EN to present a response to decode in its arrival cycle.
module stage_if_fq
    import rv_if_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               FQ_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_ctrl,
    input  logic [XLEN-1:0] br_addr,
    input  logic            flush_i,
    input  logic [XLEN-1:0] new_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] if_pc
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    if (!fq_depth_ok(FQ_DEPTH)) begin : g_bad_depth
        $error("FQ_DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inflight_pc;
    logic              inflight;
    logic              drop;
    logic              redirect;
    logic [XLEN-1:0]   target;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              resp_ok;
    logic              push;
    logic              pop;
    logic              fq_full;
    logic              fq_empty;
    logic [2*XLEN-1:0] head;
    logic [2*XLEN-1:0] resp_entry;

    assign redirect    = flush_i || br_ctrl;
    assign target      = flush_i ? new_pc_i : br_addr;
    assign occupancy   = {1'b0, count} + (CW+1)'(inflight);
    assign imem_req_o  = !rst && !redirect && (occupancy < (CW+1)'(FQ_DEPTH));
    assign imem_addr_o = pc;
    assign resp_ok     = inflight && !drop && !redirect;
    assign resp_entry  = {inflight_pc, imem_rdata_i};
    assign pop         = !redirect && !fq_empty && if_ready_i;

`ifdef IF_FQ_BYPASS_EN
    logic bypass;
    assign bypass     = fq_empty && resp_ok;
    assign if_valid_o = !redirect && (!fq_empty || bypass);
    assign push       = resp_ok && !fq_full && !(bypass && if_ready_i);
    assign {if_pc, if_inst} = !fq_empty ? head :
                              bypass    ? resp_entry : '0;
`else
    assign if_valid_o = !redirect && !fq_empty;
    assign push       = resp_ok && !fq_full;
    assign {if_pc, if_inst} = fq_empty ? '0 : head;
`endif

    if_fetch_queue #(
        .W     (2*XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (resp_entry),
        .pop   (pop),
        .clear (redirect),
        .rdata (head),
        .count (count),
        .full  (fq_full),
        .empty (fq_empty)
    );

    // A redirect discards whatever response is returning in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
        end else begin
            inflight <= imem_req_o;
            drop     <= redirect && inflight;
            if (imem_req_o) inflight_pc <= pc;
            if (redirect)
                pc <= target & ~XLEN'(3);
            else if (imem_req_o)
                pc <= pc + XLEN'(INST_BYTES);
        end
    end

endmodule

// File: tb/tb_stage_if_fq.sv
// Self-checking bench for stage_if_fq: directed scenarios plus a
// randomized run checked against a stream-level fetch model.
module tb_stage_if_fq;
    import rv_if_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef IF_FQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic            clk;
    logic            rst;
    logic            br_ctrl;
    logic [XLEN-1:0] br_addr;
    logic            flush_i;
    logic [XLEN-1:0] new_pc_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            if_valid_o;
    logic            if_ready_i;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;

    int n_cmp = 0;
    int n_bad = 0;

    logic            s_req;
    logic [XLEN-1:0] s_addr;
    logic            s_valid;
    logic [XLEN-1:0] s_pc;
    logic [XLEN-1:0] s_inst;

    fetch_entry_t    xfer_q[$];
    logic [XLEN-1:0] req_q[$];

    stage_if_fq #(
        .XLEN     (XLEN),
        .FQ_DEPTH (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .br_ctrl      (br_ctrl),
        .br_addr      (br_addr),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .if_valid_o   (if_valid_o),
        .if_ready_i   (if_ready_i),
        .if_inst      (if_inst),
        .if_pc        (if_pc)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory with 1-cycle latency; garbage when no request was made.
    always @(posedge clk)
        imem_rdata_i <= imem_req_o ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;

    // Called at a negedge with inputs applied; samples just before posedge.
    task automatic tick();
        #4;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = if_valid_o;
        s_pc    = if_pc;
        s_inst  = if_inst;
        if (!rst) begin
            if (imem_req_o) req_q.push_back(imem_addr_o);
            if (if_valid_o && if_ready_i) xfer_q.push_back({if_pc, if_inst});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; br_ctrl = 0; flush_i = 0; if_ready_i = 1;
        tick();
        tick();
        rst = 0;
        req_q.delete();
        xfer_q.delete();
    endtask

    task automatic test_reset();
        rst = 1; if_ready_i = 1;
        tick();
        n_cmp++;
        if (s_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_req: got %b want 0", s_req);
        end
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b want 0", s_valid);
        end
        n_cmp++;
        if (s_inst !== 32'h0 || s_pc !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: inst %h pc %h want 0", s_inst, s_pc);
        end
    endtask

    task automatic test_fill();
        logic [31:0] ea;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 3) begin
                ea = 32'(4 * i);
                n_cmp++;
                if (s_req !== 1'b1 || s_addr !== ea) begin
                    n_bad++;
                    $display("FAIL fill_req%0d: req %b addr %h want 1 %h", i, s_req, s_addr, ea);
                end
            end
            if (i < LAT) begin
                n_cmp++;
                if (s_valid !== 1'b0) begin
                    n_bad++; $display("FAIL fill_early%0d: valid %b want 0", i, s_valid);
                end
            end else begin
                ea = 32'(4 * (i - LAT));
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== ea || s_inst !== mem_word(ea)) begin
                    n_bad++;
                    $display("FAIL fill_out%0d: v %b pc %h inst %h want 1 %h %h",
                             i, s_valid, s_pc, s_inst, ea, mem_word(ea));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ea;
        do_reset();
        if_ready_i = 0;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (req_q.size() != DEPTH) begin
            n_bad++; $display("FAIL bp_reqs: got %0d want %0d", req_q.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH && i < req_q.size(); i++) begin
            ea = 32'(4 * i);
            n_cmp++;
            if (req_q[i] !== ea) begin
                n_bad++; $display("FAIL bp_addr%0d: got %h want %h", i, req_q[i], ea);
            end
        end
        n_cmp++;
        if (s_req !== 1'b0) begin
            n_bad++; $display("FAIL bp_stop: req %b want 0", s_req);
        end
        if_ready_i = 1;
        tick();
        n_cmp++;
        if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h0) begin
            n_bad++; $display("FAIL bp_first_pop: req %b v %b pc %h want 0 1 0", s_req, s_valid, s_pc);
        end
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h10) begin
            n_bad++; $display("FAIL bp_resume: req %b addr %h want 1 10", s_req, s_addr);
        end
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < DEPTH; i++) begin
            ea = 32'(4 * i);
            n_cmp++;
            if (i >= xfer_q.size()) begin
                n_bad++; $display("FAIL bp_drain%0d: missing want pc %h", i, ea);
            end else if (xfer_q[i].pc !== ea || xfer_q[i].inst !== mem_word(ea)) begin
                n_bad++;
                $display("FAIL bp_drain%0d: pc %h inst %h want %h %h",
                         i, xfer_q[i].pc, xfer_q[i].inst, ea, mem_word(ea));
            end
        end
    endtask

    task automatic test_branch();
        int seen;
        do_reset();
        tick(); tick(); tick();
        br_ctrl = 1; br_addr = 32'h100;
        xfer_q.delete();
        tick();
        n_cmp++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
            n_bad++; $display("FAIL br_cycle: v %b req %b want 0 0", s_valid, s_req);
        end
        br_ctrl = 0;
        seen = -1;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j == 0) begin
                n_cmp++;
                if (s_req !== 1'b1 || s_addr !== 32'h100) begin
                    n_bad++; $display("FAIL br_req: req %b addr %h want 1 100", s_req, s_addr);
                end
            end
            if (seen < 0 && s_valid) seen = j;
        end
        n_cmp++;
        if (seen != LAT) begin
            n_bad++; $display("FAIL br_latency: got %0d want %0d", seen, LAT);
        end
        n_cmp++;
        if (xfer_q.size() == 0 || xfer_q[0].pc !== 32'h100 || xfer_q[0].inst !== mem_word(32'h100)) begin
            n_bad++;
            $display("FAIL br_first_pc: got %h want 100", xfer_q.size() ? xfer_q[0].pc : 32'hX);
        end
    endtask

    task automatic test_flush_priority();
        flush_i = 1; new_pc_i = 32'h200; br_ctrl = 1; br_addr = 32'h100;
        tick();
        flush_i = 0; br_ctrl = 0;
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            n_bad++; $display("FAIL flush_prio: req %b addr %h want 1 200", s_req, s_addr);
        end
        tick(); tick();
        br_ctrl = 1; br_addr = 32'h103;
        tick();
        br_ctrl = 0;
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_bad++; $display("FAIL br_align: req %b addr %h want 1 100", s_req, s_addr);
        end
    endtask

    task automatic test_wrap();
        br_ctrl = 1; br_addr = 32'hFFFF_FFFC;
        tick();
        br_ctrl = 0;
        req_q.delete();
        xfer_q.delete();
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (req_q.size() < 2 || req_q[0] !== 32'hFFFF_FFFC || req_q[1] !== 32'h0) begin
            n_bad++; $display("FAIL wrap_req: got %h %h want fffffffc 0",
                              req_q.size() > 0 ? req_q[0] : 32'hX,
                              req_q.size() > 1 ? req_q[1] : 32'hX);
        end
        n_cmp++;
        if (xfer_q.size() < 2 || xfer_q[0].pc !== 32'hFFFF_FFFC || xfer_q[1].pc !== 32'h0 ||
            xfer_q[1].inst !== mem_word(32'h0)) begin
            n_bad++; $display("FAIL wrap_out: got %h %h want fffffffc 0",
                              xfer_q.size() > 0 ? xfer_q[0].pc : 32'hX,
                              xfer_q.size() > 1 ? xfer_q[1].pc : 32'hX);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        if_ready_i = 0;
        tick(); tick(); tick();
        n_cmp++;
        if (if_valid_o !== 1'b1) begin
            n_bad++; $display("FAIL ar_pre: valid %b want 1", if_valid_o);
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if (if_valid_o !== 1'b0 || imem_req_o !== 1'b0 ||
            if_pc !== 32'h0 || if_inst !== 32'h0) begin
            n_bad++; $display("FAIL ar_now: v %b req %b pc %h inst %h want 0 0 0 0",
                              if_valid_o, imem_req_o, if_pc, if_inst);
        end
        @(negedge clk);
        tick();
        rst = 0;
        if_ready_i = 1;
        tick();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_bad++; $display("FAIL ar_restart: req %b addr %h want 1 0", s_req, s_addr);
        end
    endtask

    // Model: requests and deliveries each follow target, target+4, ...
    // restarting at the aligned target after every redirect.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        logic [31:0] tgt;
        int          outstanding;
        int          n_xfer;
        int          r;
        logic        redir;
        do_reset();
        exp_pc = 32'h0; exp_req = 32'h0; outstanding = 0; n_xfer = 0;
        for (int c = 0; c < 600; c++) begin
            if_ready_i = ($urandom_range(0, 3) != 0) || (c >= 580);
            r = (c >= 560) ? 99 : $urandom_range(0, 24);
            flush_i  = (r == 0) || (r == 2);
            br_ctrl  = (r == 1) || (r == 2);
            new_pc_i = $urandom();
            br_addr  = $urandom();
            tgt   = flush_i ? new_pc_i : br_addr;
            redir = flush_i || br_ctrl;
            tick();
            if (redir) begin
                n_cmp++;
                if (s_req !== 1'b0 || s_valid !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_redir c%0d: req %b v %b want 0 0", c, s_req, s_valid);
                end
                exp_pc = tgt & ~32'h3;
                exp_req = exp_pc;
                outstanding = 0;
            end else begin
                if (s_req) begin
                    n_cmp++;
                    if (s_addr !== exp_req) begin
                        n_bad++; $display("FAIL rnd_req c%0d: addr %h want %h", c, s_addr, exp_req);
                    end
                    exp_req += 32'd4;
                    outstanding++;
                end
                if (s_valid && if_ready_i) begin
                    n_cmp++;
                    if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin
                        n_bad++; $display("FAIL rnd_xfer c%0d: pc %h inst %h want %h %h",
                                          c, s_pc, s_inst, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc += 32'd4;
                    outstanding--;
                    n_xfer++;
                end
                if (outstanding > DEPTH) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rnd_occupancy c%0d: got %0d max %0d", c, outstanding, DEPTH);
                end
            end
        end
        flush_i = 0; br_ctrl = 0;
        n_cmp++;
        if (n_xfer < 150) begin
            n_bad++; $display("FAIL rnd_throughput: got %0d want >=150", n_xfer);
        end
    endtask

    initial begin
        rst = 1; br_ctrl = 0; flush_i = 0; if_ready_i = 0;
        br_addr = '0; new_pc_i = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_backpressure();
        test_branch();
        test_flush_priority();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
